counter_cascade: RTL and testbench
==================================

# counter_cascade

Parametrised cascaded counter: DIGITS stages of WIDTH bits, each wrapping at its own run-time maximum, with up/down counting, synchronous parallel load and an optional one-shot mode. Stage 0 is least significant and each stage carries into the next. It extends the single-stage wrap-on-maximum counter for mixed-radix timers (e.g. sec/min/hour), prescaler chains and timeout generators.

## Interface
- WIDTH, 8: bits per stage, 1 or more.
- DIGITS, 2: number of cascaded stages, 1 or more.
- ONESHOT, 0: 0 wraps freely; 1 stops at terminal count and raises done.
- IMPLEMENTATION, 0: 0 uses carry-in (`cnt + ena`); 1 uses an enable multiplexer. Both must be cycle-identical. Any other value raises `$fatal` at elaboration.
- clk, input, 1: clock; single clock domain.
- rst, input, 1: reset, synchronous, active-high.
- ena, input, 1: count enable for stage 0.
- dir, input, 1: 0 counts up, 1 counts down.
- ld, input, 1: synchronous parallel load.
- ld_val, input, DIGITS×WIDTH: load value, packed, stage 0 in LSBs.
- max, input, DIGITS×WIDTH: per-stage maximum, packed, stage 0 in LSBs. Sampled live.
- cnt, output, DIGITS×WIDTH: counter value, registered.
- wrp, output, DIGITS: per-stage wrap event, combinational.
- ovf, output, 1: whole-counter wrap event, combinational; equals wrp[DIGITS-1].
- done, output, 1: one-shot terminal reached, registered. Constant 0 when ONESHOT=0.

## Operation
- **Terminal per stage (`term[i]`):**
  - Up: `cnt[i] >= max[i]`.
  - Down: `cnt[i] == 0`.
- **Stage carry-in:** `cin[0] = ena & ~ld & ~done`; `cin[i+1] = cin[i] & term[i]`.
- **Wrap event:** `wrp[i] = cin[i] & term[i]`. It asserts in the cycle before the wrapping edge.
- **Stage update when `cin[i]`:**
  - Up: `term[i]` gives 0, otherwise `cnt[i]+1`.
  - Down: `term[i]` gives `max[i]`, otherwise `cnt[i]-1`.
  - Without `cin[i]` the stage holds.
- **Load:** `ld` loads `ld_val` into all stages and clears `done`. Priority is rst > ld > count.
  - A loaded value above `max[i]` is stored unchanged.
  - In up mode it wraps to 0 on the next `cin[i]`.
  - In down mode it decrements normally.
- **`max[i] = 0`:** the stage stays 0, `term` is always 1, and carry passes straight through.
- **Direction change:** takes effect on the next enabled edge. No state is kept for it.
- **`max` change mid-count:** takes effect immediately through the `>=` and `==` rules above. No illegal state exists.
- **ONESHOT=1:**
  - When `ovf=1`, the next edge does not update `cnt` (it holds the terminal value) and sets `done=1`.
  - While `done=1`, `cin[0]=0`, so `wrp`/`ovf` are 0 and `ena` is ignored.
  - `ld` or `rst` clears `done`.
  - Up-mode terminal: all stages `>= max`. Down-mode terminal: all stages 0.
- **Arithmetic:** per-stage modulo 2^WIDTH internally. Never carries between stages except through `cin`. No cross-stage adder.

## Timing
- Reset values: `cnt = 0` (all stages), `done = 0`. `wrp`/`ovf` follow combinationally from `cnt`, `max`, `ena`, `dir`.
- Latency: `cnt` updates one cycle after the enabling inputs. The load is visible on `cnt` the cycle after `ld`.
- `rst` asserted mid-count: `cnt` and `done` are 0 after that edge, regardless of `ena`/`ld`.
- `ld` and `ena` together: load wins, there is no count that cycle, and `wrp=0`.
- Critical path: the `term` AND-chain across DIGITS stages. No pipelining, so `wrp`/`ovf` stay exact in the same cycle.

## Test plan
Unless stated otherwise: WIDTH=4, DIGITS=2, max={5,9}, i.e. mod-60 counting.

- **Mod-60 up count:** rst, then `ena=1` for 60 cycles.
  - `cnt` steps 00…09, 10…59, 00.
  - `wrp[0]` is high on each x9.
  - `ovf` is high only at 59, then `cnt` returns to 00.
- **Down count with borrow:** load 10, then `dir=1`, `ena=1`.
  - `cnt` goes 09, …, 00, 59.
  - `ovf` is high at 00.
- **Load above max and priority:** `ld_val={3,12}` with `ld=1` and `ena=1` in the same cycle.
  - `cnt` becomes {3,12} with no count and `wrp=0`.
  - Next enabled up edge gives {4,0}, with `wrp[0]=1` in the preceding cycle.
- **One-shot:** ONESHOT=1, up count from 00.
  - At 59 `ovf=1`; the next edge holds 59 and sets `done=1`.
  - 5 more `ena` cycles leave `cnt=59`, `ovf=0`.
  - `ld` with `ld_val=0` gives `cnt=00`, `done=0`.
- **Edge cases:**
  - `max[0]=0`: stage 1 increments on every `ena` and stage 0 stays 0.
  - Lowering `max[1]` from 5 to 2 while `cnt={4,9}`: the next enabled edge gives {0,0} with `ovf=1`.
- **Sync reset and implementation equivalence:** `rst` pulse mid-count at {3,7} gives {0,0} on the next edge, even with `ena=1` and `ld=1`. Run IMPLEMENTATION=0 and 1 side by side on random `ena`/`dir`/`ld`/`max` for 10k cycles; outputs must be identical.

Source files
------------

// File: rtl/counter_cascade.sv
// Cascaded counter: DIGITS stages of WIDTH bits, each wrapping at its own live maximum.
// Latency: cnt/done registered, one cycle after enabling inputs; wrp/ovf combinational.
// Backpressure: none; ena gates stage 0 and carries ripple through a same-cycle term chain.
module counter_cascade #(
    parameter int WIDTH          = 8,
    parameter int DIGITS         = 2,
    parameter int ONESHOT        = 0,
    parameter int IMPLEMENTATION = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ena,
    input  logic                    dir,
    input  logic                    ld,
    input  logic [DIGITS*WIDTH-1:0] ld_val,
    input  logic [DIGITS*WIDTH-1:0] max,
    output logic [DIGITS*WIDTH-1:0] cnt,
    output logic [DIGITS-1:0]       wrp,
    output logic                    ovf,
    output logic                    done
);

    if ((IMPLEMENTATION != 0 && IMPLEMENTATION != 1) || WIDTH < 1 || DIGITS < 1) begin : g_bad_param
        $fatal(1, "counter_cascade: unsupported parameter combination");
    end

    localparam bit              ONE_SHOT = (ONESHOT != 0);
    localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);

    logic [DIGITS-1:0][WIDTH-1:0] cnt_q;
    logic [DIGITS-1:0][WIDTH-1:0] cnt_nxt;
    logic [DIGITS-1:0][WIDTH-1:0] max_s;
    logic [DIGITS-1:0]            term;
    logic [DIGITS-1:0]            cin;
    logic                         done_q;
    logic                         done_s;

    assign max_s  = max;
    assign done_s = ONE_SHOT & done_q;

    always_comb begin
        logic             c;
        logic [WIDTH-1:0] wv;
        term    = '0;
        cin     = '0;
        cnt_nxt = cnt_q;
        c       = ena & ~ld & ~done_s;
        wv      = '0;
        for (int i = 0; i < DIGITS; i++) begin
            // >= rather than == so values above max (loaded, or max lowered) still wrap
            term[i] = dir ? (cnt_q[i] == '0) : (cnt_q[i] >= max_s[i]);
            cin[i]  = c;
            wv      = dir ? max_s[i] : '0;
            if (IMPLEMENTATION == 0) begin
                if (cin[i] & term[i])
                    cnt_nxt[i] = wv;
                else if (dir)
                    cnt_nxt[i] = cnt_q[i] - WIDTH'(cin[i]);
                else
                    cnt_nxt[i] = cnt_q[i] + WIDTH'(cin[i]);
            end else begin
                if (cin[i])
                    cnt_nxt[i] = term[i] ? wv : (dir ? cnt_q[i] - ONE_W : cnt_q[i] + ONE_W);
            end
            c = c & term[i];
        end
    end

    assign wrp  = cin & term;
    assign ovf  = wrp[DIGITS-1];
    assign cnt  = cnt_q;
    assign done = done_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else if (ld) begin
            cnt_q  <= ld_val;
            done_q <= 1'b0;
        end else if (ONE_SHOT && ovf) begin
            // terminal value is held; done then blocks further carries
            done_q <= 1'b1;
        end else begin
            cnt_q <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_counter_cascade.sv
// Bench for counter_cascade: four instances (free/one-shot x both implementations) against a
// per-stage arithmetic model, plus directed mod-60 scenarios with literal expectations.
module tb_counter_cascade;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       ena    = 1'b0;
    logic       dir    = 1'b0;
    logic       ld     = 1'b0;
    logic [7:0] ld_val = 8'h00;
    logic [7:0] max    = 8'h59;

    logic [7:0] cnt_o  [4];
    logic [1:0] wrp_o  [4];
    logic       ovf_o  [4];
    logic       done_o [4];

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int cyc    = 0;

    // model state: index 0 = free-running, 1 = one-shot
    int mc [2][2];
    bit md [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        counter_cascade #(
            .WIDTH(4), .DIGITS(2), .ONESHOT(g / 2), .IMPLEMENTATION(g % 2)
        ) u_dut (
            .clk(clk), .rst(rst), .ena(ena), .dir(dir), .ld(ld),
            .ld_val(ld_val), .max(max),
            .cnt(cnt_o[g]), .wrp(wrp_o[g]), .ovf(ovf_o[g]), .done(done_o[g])
        );
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int mx(input int i);
        return int'(max[i*4 +: 4]);
    endfunction

    function automatic bit mterm(input int v, input int m);
        return dir ? (v == 0) : (v >= m);
    endfunction

    function automatic logic [1:0] mwrp(input int k);
        logic [1:0] w;
        bit         c;
        c = ena && !ld && !md[k];
        for (int i = 0; i < 2; i++) begin
            w[i] = c && mterm(mc[k][i], mx(i));
            c    = w[i];
        end
        return w;
    endfunction

    function automatic int dec(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    always @(posedge clk) begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
            logic [1:0] w;
            bit         c;
            bit         t;
            w = mwrp(k);
            if (rst) begin
                mc[k][0] = 0; mc[k][1] = 0; md[k] = 1'b0;
            end else if (ld) begin
                mc[k][0] = int'(ld_val[3:0]); mc[k][1] = int'(ld_val[7:4]); md[k] = 1'b0;
            end else if (k == 1 && w[1]) begin
                md[k] = 1'b1;
            end else begin
                c = ena && !md[k];
                for (int i = 0; i < 2; i++) begin
                    t = mterm(mc[k][i], mx(i));
                    if (c) begin
                        if (t) mc[k][i] = dir ? mx(i) : 0;
                        else   mc[k][i] = dir ? mc[k][i] - 1 : mc[k][i] + 1;
                    end
                    c = c && t;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 4; d++) begin
                int         k;
                logic [1:0] w;
                logic [11:0] got, exp;
                k   = d / 2;
                w   = mwrp(k);
                got = {cnt_o[d], wrp_o[d], ovf_o[d], done_o[d]};
                exp = {mc[k][1][3:0], mc[k][0][3:0], w, w[1], md[k]};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL model dut%0d cyc %0d: got cnt/wrp/ovf/done %h expected %h",
                             d, cyc, got, exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset
        tick();
        rst = 1'b0;
        chk_en = 1'b1;
        #1;
        chk("rst_cnt", int'(cnt_o[0]), 0);
        chk("rst_done", int'(done_o[2]), 0);

        // mod-60 up count; one-shot instances reach terminal alongside
        ena = 1'b1;
        for (int n = 0; n < 60; n++) begin
            #1;
            chk("m60_cnt", dec(cnt_o[0]), n);
            chk("m60_wrp0", int'(wrp_o[0][0]), (n % 10 == 9) ? 1 : 0);
            chk("m60_ovf", int'(ovf_o[0]), (n == 59) ? 1 : 0);
            tick();
        end
        #1;
        chk("m60_back_to_00", int'(cnt_o[0]), 8'h00);
        chk("mdl_m60", mc[0][1] * 10 + mc[0][0], 0);
        chk("os_hold", int'(cnt_o[2]), 8'h59);
        chk("os_done", int'(done_o[2]), 1);
        chk("mdl_os_done", int'(md[1]), 1);
        for (int j = 0; j < 5; j++) begin
            tick();
            #1;
            chk("os_still_59", int'(cnt_o[3]), 8'h59);
            chk("os_no_ovf", int'(ovf_o[3]), 0);
        end
        ld = 1'b1; ld_val = 8'h00;
        tick();
        ld = 1'b0;
        #1;
        chk("os_ld_cnt", int'(cnt_o[2]), 8'h00);
        chk("os_ld_done", int'(done_o[2]), 0);

        // down count with borrow from 10
        ena = 1'b0; ld = 1'b1; ld_val = 8'h10;
        tick();
        ld = 1'b0; dir = 1'b1; ena = 1'b1;
        #1;
        chk("dn_load", int'(cnt_o[0]), 8'h10);
        for (int e = 9; e >= 0; e--) begin
            tick();
            #1;
            chk("dn_cnt", dec(cnt_o[1]), e);
            chk("dn_ovf", int'(ovf_o[1]), (e == 0) ? 1 : 0);
        end
        tick();
        #1;
        chk("dn_wrap_59", int'(cnt_o[1]), 8'h59);

        // load above max, load beats count
        dir = 1'b0; ena = 1'b1; ld = 1'b1; ld_val = 8'h3C;
        #1;
        chk("ld_wrp0", int'(wrp_o[0]), 0);
        tick();
        ld = 1'b0;
        #1;
        chk("ld_above_max", int'(cnt_o[0]), 8'h3C);
        chk("ld_wrp_next", int'(wrp_o[0]), 2'b01);
        tick();
        #1;
        chk("ld_wrap_to_40", int'(cnt_o[0]), 8'h40);

        // max[0]=0: stage 1 counts on every enable
        max = 8'h50; ld = 1'b1; ld_val = 8'h00;
        tick();
        ld = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            tick();
            #1;
            chk("max0_cnt", int'(cnt_o[1]), j * 16);
        end

        // lowering max[1] below the current value
        max = 8'h59; ld = 1'b1; ld_val = 8'h49;
        tick();
        ld = 1'b0; max = 8'h29;
        #1;
        chk("maxlow_ovf", int'(ovf_o[0]), 1);
        tick();
        #1;
        chk("maxlow_cnt", int'(cnt_o[0]), 8'h00);

        // sync reset beats load and enable
        max = 8'h59; ld = 1'b1; ld_val = 8'h37;
        tick();
        rst = 1'b1; ld = 1'b1; ld_val = 8'h55; ena = 1'b1;
        #1;
        chk("pre_rst", int'(cnt_o[0]), 8'h37);
        tick();
        rst = 1'b0; ld = 1'b0;
        #1;
        chk("rst_mid_f", int'(cnt_o[0]), 8'h00);
        chk("rst_mid_o", int'(cnt_o[3]), 8'h00);

        // random traffic, model compared every cycle on all instances
        for (int r = 0; r < 10000; r++) begin
            rst    = ($urandom_range(99) == 0);
            ld     = ($urandom_range(19) == 0);
            ena    = ($urandom_range(4) != 0);
            ld_val = 8'($urandom);
            if ($urandom_range(15) == 0) dir = ~dir;
            if ($urandom_range(31) == 0) max = 8'($urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
